truth_table_sequencer: RTL

Self-test controller for the 3-input/2-output combinational lab block (inputs a, b, c; outputs x, y). On a start pulse it walks {a,b,c} through all 8 combinations in ascending order and waits a programmable settle time on each. It then samples {x,y}, compares it against a parameterised expected truth table, and reports a pass flag, a mismatch count and the index of the first failure. It sits between the board-level control (pushbutton or bench) and the combinational block, so the exhaustive check runs in hardware instead of in a testbench.

---
 rtl/truth_table_sequencer_if.sv | 31 +++
 rtl/truth_table_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer_if.sv
// Bundle between the truth-table sequencer and its surroundings: the run-control
// and status signals plus the a/b/c -> x/y connection to the block under test.
interface truth_table_sequencer_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail_idx;
  logic       fail_seen;
  logic       a;
  logic       b;
  logic       c;
  logic       x;
  logic       y;
  logic [1:0] dbg_state;

  // start is a level sampled only while idle; done is a single-cycle pulse.
  // There is no ready/backpressure: a start seen outside IDLE is dropped.
  modport master (
    input  start, x, y,
    output busy, done, pass, err_count, first_fail_idx, fail_seen,
    output a, b, c, dbg_state
  );

  modport slave (
    output start, x, y,
    input  busy, done, pass, err_count, first_fail_idx, fail_seen,
    input  a, b, c, dbg_state
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Exhaustive self-test of a 3-in/2-out combinational block against a fixed truth table.
// Optional macro STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module truth_table_sequencer #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset,
  truth_table_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] err_count_q, err_count_d;
  logic [2:0] first_fail_idx_q, first_fail_idx_d;
  logic       fail_seen_q, fail_seen_d;
  logic       pass_q, pass_d;

  logic [1:0] exp_pair;
  logic       mismatch;
  logic       vec_on;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      idx_q            <= 3'd0;
      cnt_q            <= 8'd0;
      err_count_q      <= 4'd0;
      first_fail_idx_q <= 3'd0;
      fail_seen_q      <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      err_count_q      <= err_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      fail_seen_q      <= fail_seen_d;
      pass_q           <= pass_d;
    end
  end

  // Pair for vector k sits at bits [2k+1:2k], x above y.
  always_comb begin
    exp_pair = EXPECTED[{idx_q, 1'b0} +: 2];
    mismatch = ({bus.x, bus.y} != exp_pair);
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    err_count_d      = err_count_q;
    first_fail_idx_d = first_fail_idx_q;
    fail_seen_d      = fail_seen_q;
    pass_d           = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d          = ST_SETTLE;
          idx_d            = 3'd0;
          cnt_d            = 8'd0;
          err_count_d      = 4'd0;
          first_fail_idx_d = 3'd0;
          fail_seen_d      = 1'b0;
          pass_d           = 1'b0;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          err_count_d = err_count_q + 4'd1;
          if (!fail_seen_q) begin
            first_fail_idx_d = idx_q;
            fail_seen_d      = 1'b1;
          end
        end
`ifdef STOP_ON_FAIL_EN
        if (mismatch || (idx_q == 3'd7)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = ST_SETTLE;
        end
`else
        if (idx_q == 3'd7) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = ST_SETTLE;
        end
`endif
      end

      ST_DONE: begin
        // err_count_q already includes the last CHECK by now.
        pass_d  = (err_count_q == 4'd0);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Everything below is decoded from flops only; x/y never reach an output directly.
  always_comb begin
    vec_on = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  end

  assign {bus.a, bus.b, bus.c} = vec_on ? idx_q : 3'd0;
  assign bus.busy           = vec_on;
  assign bus.done           = (state_q == ST_DONE);
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_count_q;
  assign bus.first_fail_idx = first_fail_idx_q;
  assign bus.fail_seen      = fail_seen_q;
  assign bus.dbg_state      = state_q;

endmodule
